traffic_gen: RTL and testbench

- Programmable byte-stream source that feeds the production end of a FIFO through a valid/ready handshake.
- Replaces the free-running counter-plus-timer producer ahead of the read FIFO with a bounded, seedable, rate-controlled generator.
- Host-visible status (accepted-byte count, done, stall) can be returned on further channels.

---
 rtl/traffic_gen.sv | 214 +++++++++++++++++++++
 tb/tb_traffic_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen.sv
// traffic_gen: bounded, seedable, rate-controlled byte source for the
// production side of a FIFO (valid/ready handshake).
//
// Optional build macro: TRAFFIC_GEN_CHECKSUM_EN
//   When defined, adds checksum_out[7:0], the running XOR of every accepted
//   byte since the last start or reset.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no burst active; waiting for start_in
// WAIT  | idle gap between offers; gapCount counts down to 1
// OFFER | outputValid_out high; data held until accepted
// DONE  | burst length reached; done_out high until next start or reset
module traffic_gen #(
    parameter int         COUNT_WIDTH = 16,
    parameter logic [7:0] LFSR_TAPS   = 8'hB8
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic                   stop_in,
    input  logic [1:0]             mode_in,
    input  logic [7:0]             seed_in,
    input  logic [3:0]             ceiling_in,
    input  logic [7:0]             burstLen_in,
    output logic [7:0]             outputData_out,
    output logic                   outputValid_out,
    input  logic                   outputReady_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   stall_out,
`ifdef TRAFFIC_GEN_CHECKSUM_EN
    output logic [7:0]             checksum_out,
`endif
    output logic [COUNT_WIDTH-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        OFFER = 2'd2,
        DONE  = 2'd3
    } genState_e;

    localparam logic [1:0] MODE_COUNTER  = 2'b00;
    localparam logic [1:0] MODE_LFSR     = 2'b01;
    localparam logic [1:0] MODE_WALKING  = 2'b10;
    localparam logic [1:0] MODE_CONSTANT = 2'b11;

    genState_e              state;
    genState_e              stateNext;

    // Shadow configuration, captured only at start.
    logic [1:0]             modeReg;
    logic [3:0]             ceilingReg;
    logic                   continuousReg;

    logic [7:0]             remainingReg;
    logic [3:0]             gapCount;
    logic [7:0]             dataReg;
    logic [COUNT_WIDTH-1:0] countReg;
    logic                   stopFlag;

    logic                   loadConfig;
    logic                   transfer;
    logic                   lastByte;

    // First byte of a burst. An all-zero LFSR would lock up, so zero seeds
    // are promoted to 8'h01; walking-one ignores the seed entirely.
    function automatic logic [7:0] initialData(input logic [1:0] mode,
                                               input logic [7:0] seed);
        logic [7:0] value;
        value = seed;
        case (mode)
            MODE_COUNTER:  value = seed;
            MODE_LFSR:     value = (seed == 8'h00) ? 8'h01 : seed;
            MODE_WALKING:  value = 8'h01;
            MODE_CONSTANT: value = seed;
            default:       value = seed;
        endcase
        return value;
    endfunction

    // Byte that follows the given one in the selected pattern.
    function automatic logic [7:0] nextData(input logic [1:0] mode,
                                            input logic [7:0] current);
        logic [7:0] value;
        value = current;
        case (mode)
            MODE_COUNTER:  value = current + 8'd1;
            MODE_LFSR:     value = current[0] ? ((current >> 1) ^ LFSR_TAPS)
                                              : (current >> 1);
            MODE_WALKING:  value = {current[6:0], current[7]};
            MODE_CONSTANT: value = current;
            default:       value = current;
        endcase
        return value;
    endfunction

    assign lastByte = !continuousReg && (remainingReg == 8'd1);

    // State register; reset dominates every other input.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus the load/transfer strobes used by the datapath.
    always_comb begin
        stateNext  = state;
        loadConfig = 1'b0;
        transfer   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_in && !stop_in) begin
                    loadConfig = 1'b1;
                    stateNext  = (ceiling_in == 4'd0) ? OFFER : WAIT;
                end
            end
            WAIT: begin
                if (stop_in) begin
                    stateNext = IDLE;
                end else if (gapCount <= 4'd1) begin
                    stateNext = OFFER;
                end
            end
            OFFER: begin
                if (outputReady_in) begin
                    transfer = 1'b1;
                    // A stop arriving on the accepting edge itself is honoured
                    // immediately rather than costing one more byte.
                    if (lastByte) begin
                        stateNext = DONE;
                    end else if (stopFlag || stop_in) begin
                        stateNext = IDLE;
                    end else if (ceilingReg == 4'd0) begin
                        stateNext = OFFER;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Shadow config, gap timer, remaining count, data pattern and byte count.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            modeReg       <= MODE_COUNTER;
            ceilingReg    <= 4'd0;
            continuousReg <= 1'b0;
            remainingReg  <= 8'd0;
            gapCount      <= 4'd0;
            dataReg       <= 8'd0;
            countReg      <= '0;
            stopFlag      <= 1'b0;
        end else if (loadConfig) begin
            modeReg       <= mode_in;
            ceilingReg    <= ceiling_in;
            continuousReg <= (burstLen_in == 8'd0);
            remainingReg  <= burstLen_in;
            gapCount      <= ceiling_in;
            dataReg       <= initialData(mode_in, seed_in);
            countReg      <= '0;
            stopFlag      <= 1'b0;
        end else begin
            if (state == WAIT && gapCount != 4'd0) begin
                gapCount <= gapCount - 4'd1;
            end
            if (state == OFFER && stop_in) begin
                stopFlag <= 1'b1;
            end
            if (transfer) begin
                if (countReg != {COUNT_WIDTH{1'b1}}) begin
                    countReg <= countReg + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
                if (!continuousReg) begin
                    remainingReg <= remainingReg - 8'd1;
                end
                dataReg  <= nextData(modeReg, dataReg);
                gapCount <= ceilingReg;
            end
        end
    end

`ifdef TRAFFIC_GEN_CHECKSUM_EN
    logic [7:0] checksumReg;

    // Running XOR of accepted bytes, restarted with every burst.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            checksumReg <= 8'd0;
        end else if (loadConfig) begin
            checksumReg <= 8'd0;
        end else if (transfer) begin
            checksumReg <= checksumReg ^ dataReg;
        end
    end

    assign checksum_out = checksumReg;
`endif

    assign outputData_out  = dataReg;
    assign outputValid_out = (state == OFFER);
    assign busy_out        = (state == WAIT) || (state == OFFER);
    assign done_out        = (state == DONE);
    assign stall_out       = outputValid_out & ~outputReady_in;
    assign count_out       = countReg;

endmodule

// File: tb/tb_traffic_gen.sv
// Self-checking bench for traffic_gen. Expected bytes come from closed-form
// pattern rules; expected timing from a simple idle-cycle countdown.
module tb_traffic_gen;

    localparam int CW = 16;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          start_in;
    logic          stop_in;
    logic [1:0]    mode_in;
    logic [7:0]    seed_in;
    logic [3:0]    ceiling_in;
    logic [7:0]    burstLen_in;
    logic [7:0]    outputData_out;
    logic          outputValid_out;
    logic          outputReady_in;
    logic          busy_out;
    logic          done_out;
    logic          stall_out;
`ifdef TRAFFIC_GEN_CHECKSUM_EN
    logic [7:0]    checksum_out;
`endif
    logic [CW-1:0] count_out;

    int vectors = 0;
    int errors  = 0;

    traffic_gen #(.COUNT_WIDTH(CW), .LFSR_TAPS(8'hB8)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .stop_in         (stop_in),
        .mode_in         (mode_in),
        .seed_in         (seed_in),
        .ceiling_in      (ceiling_in),
        .burstLen_in     (burstLen_in),
        .outputData_out  (outputData_out),
        .outputValid_out (outputValid_out),
        .outputReady_in  (outputReady_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .stall_out       (stall_out),
`ifdef TRAFFIC_GEN_CHECKSUM_EN
        .checksum_out    (checksum_out),
`endif
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    // k-th byte (0-based) of a burst, straight from the pattern definitions.
    function automatic logic [7:0] expByte(input logic [1:0] mode,
                                           input logic [7:0] seed,
                                           input int k);
        logic [7:0] d;
        logic [7:0] one;
        one = 8'h01;
        case (mode)
            2'b00: d = seed + 8'(k);
            2'b01: begin
                d = (seed == 8'h00) ? 8'h01 : seed;
                repeat (k) d = d[0] ? ((d >> 1) ^ 8'hB8) : (d >> 1);
            end
            2'b10: d = one << (k % 8);
            default: d = seed;
        endcase
        return d;
    endfunction

    task automatic test_reset();
        reset_in = 1'b1;
        start_in = 1'b1;
        stop_in = 1'b0;
        mode_in = 2'b00;
        seed_in = 8'h55;
        ceiling_in = 4'd0;
        burstLen_in = 8'd4;
        outputReady_in = 1'b1;
        repeat (3) @(negedge clk_in);
        #1;
        vectors++;
        if ({outputValid_out, busy_out, done_out, stall_out} !== 4'b0000 ||
            count_out !== '0 || outputData_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b stall=%b count=%0d data=%h, want all 0",
                     outputValid_out, busy_out, done_out, stall_out, count_out, outputData_out);
        end
`ifdef TRAFFIC_GEN_CHECKSUM_EN
        vectors++;
        if (checksum_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_checksum: got %h want 00", checksum_out);
        end
`endif
        start_in = 1'b0;
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    // Start a burst and follow it to DONE. readyPat: 0 high, 1 toggle, 2 random.
    // noisy: scramble config inputs and pulse start_in while the burst runs.
    task automatic run_burst(input string name, input logic [1:0] mode,
                             input logic [7:0] seed, input logic [3:0] ceil,
                             input logic [7:0] len, input int readyPat,
                             input bit noisy);
        int idx = 0;
        int waitLeft;
        int cyc = 0;
        bit finished = 0;
        bit rdy;
        bit expValid;
        logic [7:0] xsum = 8'h00;
        logic [7:0] eb;
        waitLeft = int'(ceil);
        start_in = 1'b1;
        stop_in = 1'b0;
        mode_in = mode;
        seed_in = seed;
        ceiling_in = ceil;
        burstLen_in = len;
        outputReady_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        while (!finished && cyc < 500) begin
            case (readyPat)
                0: rdy = 1'b1;
                1: rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            outputReady_in = rdy;
            if (noisy) begin
                start_in = ($urandom_range(0, 3) == 0);
                mode_in = 2'($urandom);
                seed_in = 8'($urandom);
                ceiling_in = 4'($urandom);
                burstLen_in = 8'($urandom);
            end
            #1;
            expValid = (waitLeft == 0);
            eb = expByte(mode, seed, idx);
            vectors++;
            if (outputValid_out !== expValid || stall_out !== (expValid && !rdy) ||
                busy_out !== 1'b1 || done_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_ctrl cyc%0d: valid=%b stall=%b busy=%b done=%b, want valid=%b stall=%b busy=1 done=0",
                         name, cyc, outputValid_out, stall_out, busy_out, done_out,
                         expValid, expValid && !rdy);
            end
            vectors++;
            if (count_out !== CW'(idx)) begin
                errors++;
                $display("FAIL %s_count cyc%0d: got %0d want %0d", name, cyc, count_out, idx);
            end
            if (expValid) begin
                vectors++;
                if (outputData_out !== eb) begin
                    errors++;
                    $display("FAIL %s_data byte%0d: got %h want %h", name, idx, outputData_out, eb);
                end
                if (rdy) begin
                    xsum ^= eb;
                    idx++;
                    if (idx == int'(len)) finished = 1;
                    else waitLeft = int'(ceil);
                end
            end else begin
                waitLeft--;
            end
            cyc++;
            @(negedge clk_in);
        end
        start_in = 1'b0;
        if (!finished) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout: accepted %0d bytes, want %0d", name, idx, len);
        end
        #1;
        vectors++;
        if (outputValid_out !== 1'b0 || done_out !== 1'b1 || busy_out !== 1'b0 ||
            count_out !== CW'(len)) begin
            errors++;
            $display("FAIL %s_end: valid=%b done=%b busy=%b count=%0d, want 0 1 0 %0d",
                     name, outputValid_out, done_out, busy_out, count_out, len);
        end
`ifdef TRAFFIC_GEN_CHECKSUM_EN
        vectors++;
        if (checksum_out !== xsum) begin
            errors++;
            $display("FAIL %s_checksum: got %h want %h", name, checksum_out, xsum);
        end
`endif
        @(negedge clk_in);
    endtask

    task automatic test_walking_stop();
        start_in = 1'b1;
        mode_in = 2'b10;
        seed_in = 8'h3C;
        ceiling_in = 4'd0;
        burstLen_in = 8'd0;
        outputReady_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            vectors++;
            if (outputValid_out !== 1'b1 || outputData_out !== expByte(2'b10, 8'h3C, i)) begin
                errors++;
                $display("FAIL walk_data byte%0d: valid=%b data=%h want 1 %h",
                         i, outputValid_out, outputData_out, expByte(2'b10, 8'h3C, i));
            end
            @(negedge clk_in);
        end
        for (int i = 0; i < 3; i++) begin
            outputReady_in = 1'b0;
            stop_in = (i == 0);
            #1;
            vectors++;
            if (outputValid_out !== 1'b1 || stall_out !== 1'b1 || outputData_out !== 8'h02) begin
                errors++;
                $display("FAIL walk_stall cyc%0d: valid=%b stall=%b data=%h want 1 1 02",
                         i, outputValid_out, stall_out, outputData_out);
            end
            @(negedge clk_in);
        end
        stop_in = 1'b0;
        outputReady_in = 1'b1;
        #1;
        vectors++;
        if (outputValid_out !== 1'b1 || stall_out !== 1'b0 || outputData_out !== 8'h02) begin
            errors++;
            $display("FAIL walk_release: valid=%b stall=%b data=%h want 1 0 02",
                     outputValid_out, stall_out, outputData_out);
        end
        @(negedge clk_in);
        #1;
        vectors++;
        if (outputValid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
            count_out !== CW'(10)) begin
            errors++;
            $display("FAIL walk_stopped: valid=%b busy=%b done=%b count=%0d want 0 0 0 10",
                     outputValid_out, busy_out, done_out, count_out);
        end
        @(negedge clk_in);
    endtask

    task automatic test_stop_in_wait();
        start_in = 1'b1;
        mode_in = 2'b00;
        seed_in = 8'h20;
        ceiling_in = 4'd3;
        burstLen_in = 8'd5;
        outputReady_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        stop_in = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0;
        repeat (4) begin
            #1;
            vectors++;
            if (busy_out !== 1'b0 || outputValid_out !== 1'b0 || count_out !== '0) begin
                errors++;
                $display("FAIL stop_wait: busy=%b valid=%b count=%0d want 0 0 0",
                         busy_out, outputValid_out, count_out);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset_midburst();
        start_in = 1'b1;
        mode_in = 2'b00;
        seed_in = 8'h40;
        ceiling_in = 4'd0;
        burstLen_in = 8'd0;
        outputReady_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        vectors++;
        if (outputValid_out !== 1'b1 || count_out !== CW'(3) || outputData_out !== 8'h43) begin
            errors++;
            $display("FAIL midburst_pre: valid=%b count=%0d data=%h want 1 3 43",
                     outputValid_out, count_out, outputData_out);
        end
        reset_in = 1'b1;
        @(negedge clk_in);
        #1;
        vectors++;
        if (outputValid_out !== 1'b0 || count_out !== '0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: valid=%b count=%0d busy=%b want 0 0 0",
                     outputValid_out, count_out, busy_out);
        end
        reset_in = 1'b0;
        start_in = 1'b1;
        stop_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        stop_in = 1'b0;
        repeat (3) begin
            #1;
            vectors++;
            if (outputValid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
                errors++;
                $display("FAIL start_stop: valid=%b busy=%b done=%b want 0 0 0",
                         outputValid_out, busy_out, done_out);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_burst("rand", 2'($urandom), 8'($urandom), 4'($urandom_range(0, 3)),
                      8'($urandom_range(1, 12)), 2, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        run_burst("counter", 2'b00, 8'h10, 4'd0, 8'd4, 0, 1'b0);
        run_burst("lfsr", 2'b01, 8'h00, 4'd2, 8'd6, 0, 1'b0);
        test_walking_stop();
        run_burst("backpressure", 2'b00, 8'hFE, 4'd0, 8'd3, 1, 1'b0);
        run_burst("constant", 2'b11, 8'hA5, 4'd1, 8'd3, 2, 1'b0);
        run_burst("cksum_a", 2'b00, 8'h01, 4'd0, 8'd3, 0, 1'b0);
        run_burst("cksum_b", 2'b00, 8'h05, 4'd0, 8'd2, 0, 1'b0);
        test_stop_in_wait();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
